// File: rtl/alu_md.sv
// alu_md: execute-stage ALU plus an iterative multiply/divide unit with HI/LO.
//
// The single-cycle ALU result (EXALU) is purely combinational and never
// depends on the mul/div unit. The mul/div unit is a three-state FSM
// (IDLE -> RUN for W cycles -> FIX for one cycle -> IDLE). Its datapath is
// shared between multiply and divide:
//   r_acc : upper half of the product (multiply) / partial remainder (divide)
//   r_q   : multiplier shifting out, product low half shifting in (multiply)
//           dividend shifting out, quotient bits shifting in (divide)
//   r_b   : multiplicand (multiply) / divisor (divide)
// Signed operations run on magnitudes; FIX re-applies the signs.
//
// Handshake: MDVALID qualifies MDOP/EXA/EXB for the cycle in which it is high.
// An op is accepted on a rising clk edge where MDVALID=1 and MDBUSY=0. While
// MDBUSY=1, MDVALID is ignored (nothing is queued), so the pipeline must hold
// any MDOP/MFHI/MFLO until MDBUSY drops. MDDONE marks the first idle cycle
// after a multiply/divide; a new op may be accepted in that same cycle.
module alu_md #(
    parameter int W      = 32,
    parameter int SH_LSB = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   EALUC,
    input  logic [W-1:0] EXA,
    input  logic [W-1:0] EXB,
    output logic [W-1:0] EXALU,
    input  logic [2:0]   MDOP,
    input  logic         MDVALID,
    output logic         MDBUSY,
    output logic         MDDONE,
    output logic         DIVZERO,
    output logic [W-1:0] HI,
    output logic [W-1:0] LO
);

    localparam int SW = $clog2(W);

    // FSM encoding
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_FIX  = 2'b10;

    // MDOP encoding (000 and 111 are no-ops)
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    // Number of RUN iterations, one per operand bit
    localparam logic [SW:0] CNT_INIT = (SW+1)'(W);

    // ------------------------------------------------------------------
    // Single-cycle ALU
    // ------------------------------------------------------------------
    logic [SW-1:0] w_sh;
    logic          w_slt;
    logic          w_sltu;

    assign w_sh   = EXB[SH_LSB +: SW];
    assign w_slt  = $signed(EXA) < $signed(EXB);
    assign w_sltu = EXA < EXB;

    // Decode EALUC into the combinational result; unlisted codes give zero
    always_comb begin
        EXALU = '0;
        case (EALUC)
            4'b0010, 4'b0011: EXALU = EXA + EXB;
            4'b0110, 4'b1110: EXALU = EXA - EXB;
            4'b0000:          EXALU = EXA & EXB;
            4'b0001:          EXALU = EXA | EXB;
            4'b1100:          EXALU = EXA ^ EXB;
            4'b1010:          EXALU = ~(EXA | EXB);
            4'b0111:          EXALU = {{(W-1){1'b0}}, w_slt};
            4'b0101:          EXALU = {{(W-1){1'b0}}, w_sltu};
            4'b1000:          EXALU = EXA << w_sh;
            4'b1001:          EXALU = EXA >> w_sh;
            4'b1011:          EXALU = $signed(EXA) >>> w_sh;
            4'b1111:          EXALU = {EXB[W/2-1:0], {(W/2){1'b0}}};
            4'b0100:          EXALU = EXA;
            default:          EXALU = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Multiply / divide unit
    // ------------------------------------------------------------------
    logic [1:0]   r_state;
    logic [SW:0]  r_cnt;
    logic [W-1:0] r_acc;
    logic [W-1:0] r_q;
    logic [W-1:0] r_b;
    logic         r_is_div;
    logic         r_neg_q;   // product / quotient must be negated in FIX
    logic         r_neg_r;   // remainder must be negated in FIX
    logic         r_dz;      // divide with a zero divisor
    logic [W-1:0] r_hi;
    logic [W-1:0] r_lo;
    logic         r_done;
    logic         r_divz;

    logic         w_accept;
    logic         w_start;
    logic         w_signed;
    logic         w_isdiv;
    logic [W-1:0] w_a_mag;
    logic [W-1:0] w_b_mag;

    assign w_accept = MDVALID && (r_state == S_IDLE);
    assign w_start  = w_accept && ((MDOP == OP_MULT) || (MDOP == OP_MULTU) ||
                                   (MDOP == OP_DIV)  || (MDOP == OP_DIVU));
    assign w_signed = (MDOP == OP_MULT) || (MDOP == OP_DIV);
    assign w_isdiv  = (MDOP == OP_DIV)  || (MDOP == OP_DIVU);
    // The most negative value maps onto itself, which is the correct
    // unsigned magnitude 2^(W-1).
    assign w_a_mag  = (w_signed && EXA[W-1]) ? -EXA : EXA;
    assign w_b_mag  = (w_signed && EXB[W-1]) ? -EXB : EXB;

    // One shift-add step: add the multiplicand if the current multiplier bit
    // is set, then shift {acc, q} right by one, catching the carry.
    logic [W:0]   w_msum;
    assign w_msum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : {(W+1){1'b0}});

    // One restoring-divide step: shift the next dividend bit into the
    // partial remainder and subtract the divisor if it fits. The remainder
    // stays below the divisor, so the difference always fits in W bits.
    logic [W:0]   w_dshift;
    logic         w_dge;
    logic [W-1:0] w_ddiff;
    assign w_dshift = {r_acc, r_q[W-1]};
    assign w_dge    = w_dshift >= {1'b0, r_b};
    assign w_ddiff  = w_dshift[W-1:0] - r_b;

    logic [W-1:0] w_step_acc;
    logic [W-1:0] w_step_q;

    // Select the next datapath value for the running operation
    always_comb begin
        if (r_is_div) begin
            w_step_acc = w_dge ? w_ddiff : w_dshift[W-1:0];
            w_step_q   = {r_q[W-2:0], w_dge};
        end else begin
            w_step_acc = w_msum[W:1];
            w_step_q   = {w_msum[0], r_q[W-1:1]};
        end
    end

    // Sign correction applied in FIX. The overflow case -2^(W-1) / -1 needs
    // no special handling: both signs cancel and the unsigned quotient
    // 2^(W-1) is already the required bit pattern, with remainder 0.
    logic [2*W-1:0] w_prod;
    logic [2*W-1:0] w_prod_fix;
    logic [W-1:0]   w_quo;
    logic [W-1:0]   w_rem;
    assign w_prod     = {r_acc, r_q};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo      = r_neg_q ? -r_q : r_q;
    // With a zero divisor the remainder register holds |EXA|; restoring the
    // dividend sign gives EXA back exactly.
    assign w_rem      = r_neg_r ? -r_acc : r_acc;

    // FSM and iteration counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_RUN;
                        r_cnt   <= CNT_INIT;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == {{SW{1'b0}}, 1'b1}) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Operand latch on accept, then one iteration per RUN cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_q      <= '0;
            r_b      <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
        end else if (w_start) begin
            r_acc    <= '0;
            r_q      <= w_isdiv ? w_a_mag : w_b_mag;
            r_b      <= w_isdiv ? w_b_mag : w_a_mag;
            r_is_div <= w_isdiv;
            r_neg_q  <= w_signed && (EXA[W-1] ^ EXB[W-1]);
            r_neg_r  <= w_signed && w_isdiv && EXA[W-1];
            r_dz     <= w_isdiv && (EXB == '0);
        end else if (r_state == S_RUN) begin
            r_acc <= w_step_acc;
            r_q   <= w_step_q;
        end
    end

    // HI/LO: direct moves on accept, mul/div results on the edge leaving FIX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_accept && (MDOP == OP_MTHI)) begin
            r_hi <= EXA;
        end else if (w_accept && (MDOP == OP_MTLO)) begin
            r_lo <= EXA;
        end else if (r_state == S_FIX) begin
            if (r_is_div) begin
                r_hi <= w_rem;
                r_lo <= r_dz ? '1 : w_quo;
            end else begin
                {r_hi, r_lo} <= w_prod_fix;
            end
        end
    end

    // Completion pulses, high for the cycle after HI/LO update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
            r_divz <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIX);
            r_divz <= (r_state == S_FIX) && r_is_div && r_dz;
        end
    end

    assign MDBUSY  = (r_state != S_IDLE);
    assign MDDONE  = r_done;
    assign DIVZERO = r_divz;
    assign HI      = r_hi;
    assign LO      = r_lo;

endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: directed and randomized checks of alu_md (W=32) against a
// reference model written with plain integer arithmetic.
module tb_alu_md;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic [3:0]   ealuc;
  logic [W-1:0] exa;
  logic [W-1:0] exb;
  logic [W-1:0] exalu;
  logic [2:0]   mdop;
  logic         mdvalid;
  logic         mdbusy;
  logic         mddone;
  logic         divzero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboard: expected {divzero, hi, lo} per issued multiply/divide
  logic [2*W:0] exp_q[$];

  // model of the architectural HI/LO registers
  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  alu_md #(.W(W), .SH_LSB(6)) dut (
    .clk     (clk),
    .rst     (rst),
    .EALUC   (ealuc),
    .EXA     (exa),
    .EXB     (exb),
    .EXALU   (exalu),
    .MDOP    (mdop),
    .MDVALID (mdvalid),
    .MDBUSY  (mdbusy),
    .MDDONE  (mddone),
    .DIVZERO (divzero),
    .HI      (hi),
    .LO      (lo)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference models ----------------
  function automatic logic [W-1:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int unsigned sh;
    int          sa;
    int          sb;
    sh = (b / 64) % 32;
    sa = a;
    sb = b;
    case (op)
      4'd2, 4'd3:   return a + b;
      4'd6, 4'd14:  return a - b;
      4'd0:         return a & b;
      4'd1:         return a | b;
      4'd12:        return a ^ b;
      4'd10:        return ~(a | b);
      4'd7:         return (sa < sb) ? 32'd1 : 32'd0;
      4'd5:         return (a < b) ? 32'd1 : 32'd0;
      4'd8:         return a << sh;
      4'd9:         return a >> sh;
      4'd11:        return sa >>> sh;
      4'd15:        return b * 32'd65536;
      4'd4:         return a;
      default:      return 32'd0;
    endcase
  endfunction

  function automatic logic [2*W:0] md_ref(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    longint      p;
    logic [63:0] pu;
    int          sa;
    int          sb;
    sa = a;
    sb = b;
    case (op)
      3'd1: begin
        p = longint'(sa) * longint'(sb);
        return {1'b0, 64'(p)};
      end
      3'd2: begin
        pu = {32'd0, a} * {32'd0, b};
        return {1'b0, pu};
      end
      3'd3: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
        return {1'b0, 32'(sa % sb), 32'(sa / sb)};
      end
      3'd4: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
      default: return '0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic alu_case(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
    @(negedge clk);
    ealuc = op;
    exa   = a;
    exb   = b;
    #1;
    check(tag, 64'(exalu), 64'(alu_ref(op, a, b)));
  endtask

  // Issue one MDOP. no_wait: drive on the current negedge (back-to-back).
  // chain: caller issues the next op right at the MDDONE cycle.
  // inject: try an MTLO while busy, which must be ignored.
  task automatic do_md(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit inject, input bit no_wait, input bit chain);
    logic [2*W:0] e;
    int           cyc;
    bit           held;
    if (!no_wait) @(negedge clk);
    exa     = a;
    exb     = b;
    mdop    = op;
    mdvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mdvalid = 1'b0;
    mdop    = 3'd0;
    if (op == 3'd5 || op == 3'd6 || op == 3'd0 || op == 3'd7) begin
      if (op == 3'd5) m_hi = a;
      if (op == 3'd6) m_lo = a;
      check("mv_busy", 64'(mdbusy), 64'd0);
      check("mv_hi", 64'(hi), 64'(m_hi));
      check("mv_lo", 64'(lo), 64'(m_lo));
      check("mv_done", 64'(mddone), 64'd0);
      return;
    end
    exp_q.push_back(md_ref(op, a, b));
    cyc  = 0;
    held = 1'b1;
    while (mdbusy === 1'b1 && cyc < 200) begin
      cyc++;
      if (hi !== m_hi || lo !== m_lo || mddone !== 1'b0 || divzero !== 1'b0) held = 1'b0;
      if (inject && cyc == 5) begin
        exa     = 32'h0000_00AA;
        mdop    = 3'd6;
        mdvalid = 1'b1;
      end else if (inject && cyc == 6) begin
        mdvalid = 1'b0;
        mdop    = 3'd0;
      end
      @(negedge clk);
    end
    check("busy_cycles", 64'(cyc), 64'd33);
    check("held_while_busy", 64'(held), 64'd1);
    check("mddone", 64'(mddone), 64'd1);
    check("sb_size", 64'(exp_q.size()), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("hi", 64'(hi), 64'(e[2*W-1:W]));
      check("lo", 64'(lo), 64'(e[W-1:0]));
      check("divzero", 64'(divzero), 64'(e[2*W]));
      m_hi = e[2*W-1:W];
      m_lo = e[W-1:0];
    end
    if (!chain) begin
      @(negedge clk);
      check("mddone_pulse", 64'(mddone), 64'd0);
      check("divzero_pulse", 64'(divzero), 64'd0);
    end
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0] op;
    int         quiet;
    rst     = 1'b1;
    ealuc   = 4'd0;
    exa     = '0;
    exb     = '0;
    mdop    = 3'd0;
    mdvalid = 1'b0;
    m_hi    = '0;
    m_lo    = '0;
    repeat (2) @(negedge clk);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(mdbusy), 64'd0);
    check("rst_done", 64'(mddone), 64'd0);
    check("rst_divzero", 64'(divzero), 64'd0);
    rst = 1'b0;

    // directed ALU cases
    alu_case("slt_neg1_lt_1", 4'b0111, 32'hFFFF_FFFF, 32'h0000_0001);
    check("slt_const", 64'(exalu), 64'd1);
    alu_case("sltu_big", 4'b0101, 32'hFFFF_FFFF, 32'h0000_0001);
    check("sltu_const", 64'(exalu), 64'd0);
    alu_case("sra_sh4", 4'b1011, 32'h8000_0000, 32'h0000_0100);
    check("sra_const", 64'(exalu), 64'hF800_0000);
    alu_case("lui", 4'b1111, 32'h1234_5678, 32'hABCD_9876);
    alu_case("unlisted", 4'b1101, 32'h1234_5678, 32'hABCD_9876);

    // directed mul/div cases
    do_md(3'd1, 32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0, 1'b0);
    check("mult_neg_lo", 64'(lo), 64'hFFFF_FFEB);
    do_md(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    check("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    do_md(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 1'b0);
    check("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);
    do_md(3'd4, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
    do_md(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    do_md(3'd4, 32'h0000_1234, 32'd0, 1'b0, 1'b0, 1'b0);
    check("divu0_hi", 64'(hi), 64'h0000_1234);
    do_md(3'd3, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0, 1'b0);
    do_md(3'd5, 32'h0000_0055, 32'd0, 1'b0, 1'b0, 1'b0);
    check("mthi_55", 64'(hi), 64'h55);

    // asynchronous reset in the middle of a multiply
    @(negedge clk);
    exa     = 32'd5;
    exb     = 32'd9;
    mdop    = 3'd1;
    mdvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mdvalid = 1'b0;
    mdop    = 3'd0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 64'(mdbusy), 64'd0);
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst   = 1'b0;
    quiet = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mddone !== 1'b0 || mdbusy !== 1'b0) quiet = 0;
    end
    check("arst_no_done", 64'(quiet), 64'd1);
    do_md(3'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0);
    check("after_rst_lo", 64'(lo), 64'd6);
    check("after_rst_hi", 64'(hi), 64'd0);

    // randomized ALU
    for (int i = 0; i < 60; i++) begin
      alu_case("alu_rand", 4'($urandom_range(0, 15)), rand_operand(), rand_operand());
    end

    // randomized mul/div/moves, occasionally back-to-back
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      do_md(op, rand_operand(), rand_operand(), ($urandom_range(0, 3) == 0), 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
